// File: rtl/wb_commit_queue.sv
// wb_commit_queue
// In-order writeback queue on the write side of the dual-issue register file.
// Up to two completed results per cycle are buffered in a circular FIFO.
// Up to two entries per cycle drain onto register file write ports 0/1 in
// program order. Decode gets a combinational lookup of queued values.
// Address 32 is the 64-bit HI/LO pair, and 1..31 are GPRs.
//
// Ports
//   clk, resetn             clock, synchronous active-low reset
//   flush                   discard all queued entries
//   commit_en               drain permitted this cycle
//   in0_* / in1_*           older / younger completed result (valid, we, waddr, wdata)
//   in_ready                room for two entries (from registered occupancy only)
//   we0/waddr0/wdata0       register file write port 0 (older)
//   we1/waddr1/wdata1       register file write port 1 (younger)
//   fwd_raddr               forwarding lookup address
//   fwd_hit, fwd_data       queued pending write to fwd_raddr, youngest value
//   count                   current occupancy
module wb_commit_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             commit_en,
    input  logic             in0_valid,
    input  logic             in0_we,
    input  logic [5:0]       in0_waddr,
    input  logic [63:0]      in0_wdata,
    input  logic             in1_valid,
    input  logic             in1_we,
    input  logic [5:0]       in1_waddr,
    input  logic [63:0]      in1_wdata,
    output logic             in_ready,
    output logic             we0,
    output logic [5:0]       waddr0,
    output logic [63:0]      wdata0,
    output logic             we1,
    output logic [5:0]       waddr1,
    output logic [63:0]      wdata1,
    input  logic [5:0]       fwd_raddr,
    output logic             fwd_hit,
    output logic [63:0]      fwd_data,
    output logic [PTR_W:0]   count
);

    // Highest occupancy that still leaves room for a full pair.
    localparam logic [PTR_W:0] READY_MAX_C = (PTR_W + 1)'(DEPTH - 2);

    logic [5:0]       addr_mem_r [DEPTH];
    logic [63:0]      data_mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;

    logic             we0_r;
    logic [5:0]       waddr0_r;
    logic [63:0]      wdata0_r;
    logic             we1_r;
    logic [5:0]       waddr1_r;
    logic [63:0]      wdata1_r;

    logic             in_ready_s;
    logic             q0_s;
    logic             q1_s;
    logic [PTR_W-1:0] slot1_ptr_s;
    logic [1:0]       enq_cnt_s;
    logic [1:0]       drain_cnt_s;
    logic [PTR_W-1:0] head1_s;
    logic             fwd_hit_s;
    logic [63:0]      fwd_data_s;
    logic             match_s;

    // Enqueue qualification and slot placement; a dropped slot 0 lets slot 1 take the tail.
    always_comb begin
        in_ready_s  = (count_r <= READY_MAX_C);
        q0_s        = in_ready_s & in0_valid & in0_we & (in0_waddr != 6'd0);
        q1_s        = in_ready_s & in1_valid & in1_we & (in1_waddr != 6'd0);
        slot1_ptr_s = q0_s ? (tail_r + PTR_W'(1)) : tail_r;
        enq_cnt_s   = {1'b0, q0_s} + {1'b0, q1_s};
        head1_s     = head_r + PTR_W'(1);
    end

    // Drain amount: up to two entries when committing, never more than are held.
    always_comb begin
        drain_cnt_s = 2'd0;
        if (!commit_en) begin
            drain_cnt_s = 2'd0;
        end else if (count_r >= (PTR_W + 1)'(2)) begin
            drain_cnt_s = 2'd2;
        end else begin
            drain_cnt_s = count_r[1:0];
        end
    end

    // Queue storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            if (q0_s) begin
                addr_mem_r[tail_r] <= in0_waddr;
                data_mem_r[tail_r] <= in0_wdata;
            end else begin
                addr_mem_r[tail_r] <= addr_mem_r[tail_r];
                data_mem_r[tail_r] <= data_mem_r[tail_r];
            end
            if (q1_s) begin
                addr_mem_r[slot1_ptr_s] <= in1_waddr;
                data_mem_r[slot1_ptr_s] <= in1_wdata;
            end else begin
                addr_mem_r[slot1_ptr_s] <= addr_mem_r[slot1_ptr_s];
                data_mem_r[slot1_ptr_s] <= data_mem_r[slot1_ptr_s];
            end
        end else begin
            addr_mem_r[tail_r] <= addr_mem_r[tail_r];
            data_mem_r[tail_r] <= data_mem_r[tail_r];
        end
    end

    // Pointers, occupancy and registered write ports; flush and reset empty the queue.
    // Idle ports carry zero address/data because the regfile bypass ignores we.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head_r   <= {PTR_W{1'b0}};
            tail_r   <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
            we0_r    <= 1'b0;
            waddr0_r <= 6'd0;
            wdata0_r <= 64'd0;
            we1_r    <= 1'b0;
            waddr1_r <= 6'd0;
            wdata1_r <= 64'd0;
        end else begin
            head_r  <= head_r + PTR_W'(drain_cnt_s);
            tail_r  <= tail_r + PTR_W'(enq_cnt_s);
            count_r <= count_r + (PTR_W + 1)'(enq_cnt_s) - (PTR_W + 1)'(drain_cnt_s);
            if (drain_cnt_s >= 2'd1) begin
                we0_r    <= 1'b1;
                waddr0_r <= addr_mem_r[head_r];
                wdata0_r <= data_mem_r[head_r];
            end else begin
                we0_r    <= 1'b0;
                waddr0_r <= 6'd0;
                wdata0_r <= 64'd0;
            end
            if (drain_cnt_s == 2'd2) begin
                we1_r    <= 1'b1;
                waddr1_r <= addr_mem_r[head1_s];
                wdata1_r <= data_mem_r[head1_s];
            end else begin
                we1_r    <= 1'b0;
                waddr1_r <= 6'd0;
                wdata1_r <= 64'd0;
            end
        end
    end

    // Forwarding scan from oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 64'd0;
        match_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s    = ((PTR_W + 1)'(i) < count_r) &&
                         (fwd_raddr != 6'd0) &&
                         (addr_mem_r[head_r + PTR_W'(i)] == fwd_raddr);
            fwd_hit_s  = fwd_hit_s | match_s;
            fwd_data_s = match_s ? data_mem_r[head_r + PTR_W'(i)] : fwd_data_s;
        end
    end

    assign in_ready = in_ready_s;
    assign we0      = we0_r;
    assign waddr0   = waddr0_r;
    assign wdata0   = wdata0_r;
    assign we1      = we1_r;
    assign waddr1   = waddr1_r;
    assign wdata1   = wdata1_r;
    assign fwd_hit  = fwd_hit_s;
    assign fwd_data = fwd_data_s;
    assign count    = count_r;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: directed steps followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_wb_commit_queue;

    logic        clk = 1'b0;
    logic        resetn, flush, commit_en;
    logic        in0_valid, in0_we, in1_valid, in1_we;
    logic [5:0]  in0_waddr, in1_waddr, fwd_raddr, waddr0, waddr1;
    logic [63:0] in0_wdata, in1_wdata, wdata0, wdata1, fwd_data;
    logic        in_ready, we0, we1, fwd_hit;
    logic [3:0]  count;

    int total  = 0;
    int passed = 0;

    // Reference model: program-ordered list of pending writes.
    logic [5:0]  m_addr [$];
    logic [63:0] m_data [$];
    logic        e_we0, e_we1;
    logic [5:0]  e_wa0, e_wa1;
    logic [63:0] e_wd0, e_wd1;

    always #5 clk = ~clk;

    wb_commit_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .commit_en(commit_en),
        .in0_valid(in0_valid), .in0_we(in0_we), .in0_waddr(in0_waddr), .in0_wdata(in0_wdata),
        .in1_valid(in1_valid), .in1_we(in1_we), .in1_waddr(in1_waddr), .in1_wdata(in1_wdata),
        .in_ready(in_ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_fwd();
        logic        hit = 1'b0;
        logic [63:0] d   = 64'd0;
        if (fwd_raddr != 6'd0) begin
            foreach (m_addr[i]) begin
                if (m_addr[i] == fwd_raddr) begin
                    hit = 1'b1;
                    d   = m_data[i];
                end
            end
        end
        chk("fwd_hit", fwd_hit, hit);
        chk("fwd_data", fwd_data, d);
    endtask

    task automatic idle_inputs();
        in0_valid = 1'b0; in0_we = 1'b0; in0_waddr = 6'd0; in0_wdata = 64'd0;
        in1_valid = 1'b0; in1_we = 1'b0; in1_waddr = 6'd0; in1_wdata = 64'd0;
    endtask

    task automatic set_pair(input logic [5:0] a0, input logic [63:0] d0,
                            input logic [5:0] a1, input logic [63:0] d1);
        in0_valid = 1'b1; in0_we = 1'b1; in0_waddr = a0; in0_wdata = d0;
        in1_valid = 1'b1; in1_we = 1'b1; in1_waddr = a1; in1_wdata = d1;
    endtask

    // One clock: update the model with the rules, advance, compare all outputs.
    task automatic cycle();
        bit ready = (m_addr.size() <= 6);
        int n;
        e_we0 = 1'b0; e_wa0 = 6'd0; e_wd0 = 64'd0;
        e_we1 = 1'b0; e_wa1 = 6'd0; e_wd1 = 64'd0;
        if (!resetn || flush) begin
            m_addr.delete();
            m_data.delete();
        end else begin
            n = commit_en ? ((m_addr.size() >= 2) ? 2 : m_addr.size()) : 0;
            if (n >= 1) begin
                e_we0 = 1'b1; e_wa0 = m_addr.pop_front(); e_wd0 = m_data.pop_front();
            end
            if (n >= 2) begin
                e_we1 = 1'b1; e_wa1 = m_addr.pop_front(); e_wd1 = m_data.pop_front();
            end
            if (ready) begin
                if (in0_valid && in0_we && in0_waddr != 6'd0) begin
                    m_addr.push_back(in0_waddr); m_data.push_back(in0_wdata);
                end
                if (in1_valid && in1_we && in1_waddr != 6'd0) begin
                    m_addr.push_back(in1_waddr); m_data.push_back(in1_wdata);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("we0", we0, e_we0);
        chk("waddr0", waddr0, e_wa0);
        chk("wdata0", wdata0, e_wd0);
        chk("we1", we1, e_we1);
        chk("waddr1", waddr1, e_wa1);
        chk("wdata1", wdata1, e_wd1);
        chk("count", count, 64'(m_addr.size()));
        chk("in_ready", in_ready, (m_addr.size() <= 6));
        chk_fwd();
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; commit_en = 1'b0; fwd_raddr = 6'd0;
        idle_inputs();

        // Reset state
        cycle();
        cycle();
        chk("reset_count", count, 64'd0);
        resetn = 1'b1;

        // Pair enqueue, drained on the following edge, then idle ports
        commit_en = 1'b1;
        set_pair(6'd5, 64'h11, 6'd6, 64'h22);
        cycle();
        idle_inputs();
        cycle();
        chk("pair_we0", we0, 1'b1);
        chk("pair_wdata1", wdata1, 64'h22);
        cycle();
        chk("pair_idle_waddr0", waddr0, 6'd0);

        // Fill to DEPTH with commit held off; fifth pair must be ignored
        commit_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_pair(6'(2 * i + 1), 64'(100 + 2 * i), 6'(2 * i + 2), 64'(101 + 2 * i));
            cycle();
        end
        chk("full_count", count, 64'd8);
        chk("full_ready", in_ready, 1'b0);
        set_pair(6'd20, 64'hDEAD, 6'd21, 64'hBEEF);
        cycle();
        chk("full_ignored", count, 64'd8);
        idle_inputs();
        commit_en = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("drained_count", count, 64'd0);

        // Forwarding: youngest of two r3 writes
        commit_en = 1'b0;
        in0_valid = 1'b1; in0_we = 1'b1; in0_waddr = 6'd3; in0_wdata = 64'hA;
        cycle();
        in0_wdata = 64'hB;
        cycle();
        idle_inputs();
        fwd_raddr = 6'd3; #1;
        chk("fwd_r3_hit", fwd_hit, 1'b1);
        chk("fwd_r3_data", fwd_data, 64'hB);
        fwd_raddr = 6'd0; #1;
        chk("fwd_r0_hit", fwd_hit, 1'b0);
        fwd_raddr = 6'd7; #1;
        chk("fwd_r7_hit", fwd_hit, 1'b0);
        commit_en = 1'b1;
        cycle();
        cycle();

        // HI/LO in slot 1 with a store (we=0) in slot 0
        commit_en = 1'b0;
        in0_valid = 1'b1; in0_we = 1'b0; in0_waddr = 6'd9; in0_wdata = 64'h55;
        in1_valid = 1'b1; in1_we = 1'b1; in1_waddr = 6'd32; in1_wdata = 64'h0000000100000002;
        cycle();
        chk("hilo_count", count, 64'd1);
        idle_inputs();
        commit_en = 1'b1;
        cycle();
        chk("hilo_waddr0", waddr0, 6'd32);
        chk("hilo_wdata0", wdata0, 64'h0000000100000002);
        cycle();

        // Flush with a pending drain at the same edge
        commit_en = 1'b0;
        set_pair(6'd10, 64'h1010, 6'd11, 64'h1111);
        cycle();
        in1_valid = 1'b0; in0_waddr = 6'd12; in0_wdata = 64'h1212;
        cycle();
        idle_inputs();
        commit_en = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_count", count, 64'd0);
        chk("flush_we0", we0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();

        // Random mixed traffic across many pointer wraps
        for (int c = 0; c < 400; c++) begin
            in0_valid = 1'($urandom_range(0, 1)); in0_we = ($urandom_range(0, 4) != 0);
            in0_waddr = 6'($urandom_range(0, 32));
            in0_wdata = (in0_waddr == 6'd32) ? {32'($urandom), 32'($urandom)} : {32'd0, 32'($urandom)};
            in1_valid = 1'($urandom_range(0, 1)); in1_we = ($urandom_range(0, 4) != 0);
            in1_waddr = 6'($urandom_range(0, 32));
            in1_wdata = (in1_waddr == 6'd32) ? {32'($urandom), 32'($urandom)} : {32'd0, 32'($urandom)};
            commit_en = ($urandom_range(0, 99) < ((c < 200) ? 40 : 75));
            flush     = ($urandom_range(0, 59) == 0);
            fwd_raddr = 6'($urandom_range(0, 32));
            cycle();
            chk("count_bound", (count <= 4'd8), 1'b1);
        end
        flush = 1'b0;
        idle_inputs();
        commit_en = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
